// File: rtl/sobel_pkg.sv
// sobel_pkg: shared FSM states, stage phase offsets and default geometry for the Sobel pipeline.
package sobel_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;
  localparam int POP_OFS = 0;
  localparam int SHIFT_OFS = 1;
  localparam int HOLD_OFS = 2;
  localparam int MAG_OFS = 3;
  localparam int OUT_OFS = 4;
  localparam int DEF_IMG_W = 512;
  localparam int DEF_IMG_H = 512;
  localparam int DEF_PIX_PER_WORD = 8;
  localparam int DEF_ROW_STEP = 2;
  localparam int DEF_RAM_LAT = 1;
  localparam int DEF_SLOT_LEN = 8;
  localparam int DEF_DRAIN_SLOTS = 2;
  localparam int DEF_ADDR_W = 20;
  // {pop, shift, hold, mag, out} for a given slot phase
  function automatic logic [4:0] stageStrobes(int phase, int ramLat);
    return {phase == ramLat + POP_OFS, phase == ramLat + SHIFT_OFS, phase == ramLat + HOLD_OFS,
            phase == ramLat + MAG_OFS, phase == ramLat + OUT_OFS};
  endfunction
endpackage

// File: rtl/sobel_addr_gen.sv
// sobel_addr_gen: col/row/word counters and registered frame-buffer word address.
module sobel_addr_gen #(
  parameter int WPR = 4,
  parameter int ROW_STEP = 2,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] word,
  output logic [ADDR_W-1:0] readAddr
);
  logic [ADDR_W-1:0] col, row, nxtCol, nxtRow;
  logic colWrap;
  always_comb begin
    colWrap = col == ADDR_W'(WPR - 1);
    nxtCol = colWrap ? '0 : col + ADDR_W'(1);
    nxtRow = colWrap ? row + ADDR_W'(ROW_STEP) : row;
  end
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
      word <= '0;
      readAddr <= '0;
    end else if (step) begin
      col <= nxtCol;
      row <= nxtRow;
      word <= word + ADDR_W'(1);
      readAddr <= nxtRow * ADDR_W'(WPR) + nxtCol;
    end
  end
endmodule

// File: rtl/sobel_stage_sequencer.sv
// sobel_stage_sequencer: per-word slot scheduler driving read address, stage strobes,
// early next-frame request and end-of-frame pulse for the Sobel pipeline.
module sobel_stage_sequencer import sobel_pkg::*; #(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
  parameter int ROW_STEP = DEF_ROW_STEP,
  parameter int RAM_LAT = DEF_RAM_LAT,
  parameter int SLOT_LEN = DEF_SLOT_LEN,
  parameter int DRAIN_SLOTS = DEF_DRAIN_SLOTS,
  parameter int NEXT_NUM = 4,
  parameter int NEXT_DEN = 5,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startEn,
  input  logic              stall,
  output logic [ADDR_W-1:0] read_addr,
  output logic              popBufferEn,
  output logic              sobelShiftEn,
  output logic              HoldEn,
  output logic              startMultiplierEn,
  output logic              startMagEn,
  output logic              startDirEn,
  output logic              outEn,
  output logic              getNext,
  output logic              busy,
  output logic              done
);
  localparam int WPR = IMG_W / PIX_PER_WORD;
  localparam int ROWS = IMG_H / ROW_STEP;
  localparam int TOTAL = ROWS * WPR;
  localparam int NEXT_IDX = TOTAL * NEXT_NUM / NEXT_DEN;
  localparam int PH_W = $clog2(SLOT_LEN);
  localparam int DR_W = $clog2(DRAIN_SLOTS + 2);
  if (IMG_W % PIX_PER_WORD != 0 || IMG_H % ROW_STEP != 0 || SLOT_LEN < RAM_LAT + 5) begin : gBadCfg
    $error("sobel_stage_sequencer: invalid geometry or slot length");
  end
  stateT state;
  logic [PH_W-1:0] ph, phNext;
  logic [DR_W-1:0] drainCnt;
  logic [ADDR_W-1:0] word;
  logic [4:0] stb;
  logic slotEnd, lastWord, step, clear, popOk, finish;
  always_comb begin
    slotEnd = ph == PH_W'(SLOT_LEN - 1);
    lastWord = word == ADDR_W'(TOTAL - 1);
    phNext = slotEnd ? '0 : ph + PH_W'(1);
    stb = stageStrobes(int'(phNext), RAM_LAT);
    clear = state == IDLE && startEn;
    step = state == RUN && !stall && slotEnd && !lastWord;
    popOk = state == RUN && !(slotEnd && lastWord);
    finish = slotEnd && (state == DRAIN ? drainCnt == DR_W'(DRAIN_SLOTS - 1) : lastWord && DRAIN_SLOTS == 0);
  end
  sobel_addr_gen #(.WPR(WPR), .ROW_STEP(ROW_STEP), .ADDR_W(ADDR_W)) uAddr (
    .clk(clk), .reset(reset), .clear(clear), .step(step), .word(word), .readAddr(read_addr)
  );
  assign startMultiplierEn = HoldEn;
  assign startDirEn = startMagEn;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ph <= '0;
      drainCnt <= '0;
      {popBufferEn, sobelShiftEn, HoldEn, startMagEn, outEn} <= '0;
      getNext <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      {popBufferEn, sobelShiftEn, HoldEn, startMagEn, outEn} <= '0;
      getNext <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (startEn) begin
          state <= RUN;
          ph <= '0;
          drainCnt <= '0;
          busy <= 1'b1;
          {popBufferEn, sobelShiftEn, HoldEn, startMagEn, outEn} <= stageStrobes(0, RAM_LAT);
          getNext <= NEXT_IDX == 0;
        end
        RUN, DRAIN: if (!stall) begin
          ph <= phNext;
          if (finish) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            {popBufferEn, sobelShiftEn, HoldEn, startMagEn, outEn} <= stb & {popOk, 4'hf};
            getNext <= step && word == ADDR_W'(NEXT_IDX - 1);
            if (slotEnd && state == RUN && lastWord) state <= DRAIN;
            if (slotEnd && state == DRAIN) drainCnt <= drainCnt + DR_W'(1);
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_stage_sequencer.sv
// tb_sobel_stage_sequencer: directed, table-driven checks of the Sobel stage sequencer
// (ROW_STEP=2 instance A, ROW_STEP=1 instance B sharing the same stimulus).
module tb_sobel_stage_sequencer;
  localparam int AW = 20;
  localparam int N = 400;
  logic clk = 1'b0, reset = 1'b1, startEn = 1'b0, stall = 1'b0;
  always #5 clk = ~clk;
  logic [AW-1:0] addrA, addrB;
  logic popA, shA, hoA, muA, maA, diA, ouA, gnA, buA, doA;
  logic popB, shB, hoB, muB, maB, diB, ouB, gnB, buB, doB;
  sobel_stage_sequencer #(.IMG_W(32), .IMG_H(8), .PIX_PER_WORD(8), .ROW_STEP(2), .RAM_LAT(1),
    .SLOT_LEN(8), .DRAIN_SLOTS(2), .NEXT_NUM(4), .NEXT_DEN(5), .ADDR_W(AW)) dutA (
    .clk(clk), .reset(reset), .startEn(startEn), .stall(stall), .read_addr(addrA),
    .popBufferEn(popA), .sobelShiftEn(shA), .HoldEn(hoA), .startMultiplierEn(muA),
    .startMagEn(maA), .startDirEn(diA), .outEn(ouA), .getNext(gnA), .busy(buA), .done(doA));
  sobel_stage_sequencer #(.IMG_W(32), .IMG_H(8), .PIX_PER_WORD(8), .ROW_STEP(1), .RAM_LAT(1),
    .SLOT_LEN(8), .DRAIN_SLOTS(2), .NEXT_NUM(4), .NEXT_DEN(5), .ADDR_W(AW)) dutB (
    .clk(clk), .reset(reset), .startEn(startEn), .stall(stall), .read_addr(addrB),
    .popBufferEn(popB), .sobelShiftEn(shB), .HoldEn(hoB), .startMultiplierEn(muB),
    .startMagEn(maB), .startDirEn(diB), .outEn(ouB), .getNext(gnB), .busy(buB), .done(doB));
  // bit order: pop shift hold mult mag dir out getNext busy done
  wire [9:0] vecA = {popA, shA, hoA, muA, maA, diA, ouA, gnA, buA, doA};
  wire [9:0] vecB = {popB, shB, hoB, muB, maB, diB, ouB, gnB, buB, doB};
  logic [9:0] obsA[N], obsB[N];
  logic [AW-1:0] adA[N], adB[N];
  bit stT[N], stS[N], stR[N];
  int checks = 0, failures = 0;
  typedef struct {int cyc; logic [9:0] bits; int addr;} vec_t;
  vec_t tab[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic checkTab(string tag);
    foreach (tab[i]) begin
      chk($sformatf("%s_c%0d_strobes", tag, tab[i].cyc), int'(obsA[tab[i].cyc]), int'(tab[i].bits));
      chk($sformatf("%s_c%0d_addr", tag, tab[i].cyc), int'(adA[tab[i].cyc]), tab[i].addr);
    end
  endtask

  function automatic int cnt(bit useB, int b, int lo, int hi);
    int s = 0;
    for (int c = lo; c <= hi; c++) s += useB ? int'(obsB[c][b]) : int'(obsA[c][b]);
    return s;
  endfunction

  task automatic prep();
    for (int i = 0; i < N; i++) begin
      stT[i] = 1'b0;
      stS[i] = 1'b0;
      stR[i] = 1'b0;
    end
    startEn = 1'b0;
    stall = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // cycle c: inputs set here are sampled at the closing edge, outputs observed mid-cycle
  task automatic run(int n);
    for (int c = 0; c < n; c++) begin
      startEn = stT[c];
      stall = stS[c];
      reset = stR[c];
      @(negedge clk);
      obsA[c] = vecA;
      adA[c] = addrA;
      obsB[c] = vecB;
      adB[c] = addrB;
      @(posedge clk);
      #1;
    end
    startEn = 1'b0;
    stall = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    // nominal frame
    prep();
    stT[0] = 1'b1;
    run(290);
    tab = '{'{0, 10'b0000000000, 0}, '{1, 10'b0000000010, 0}, '{2, 10'b1000000010, 0},
            '{3, 10'b0100000010, 0}, '{4, 10'b0011000010, 0}, '{5, 10'b0000110010, 0},
            '{6, 10'b0000001010, 0}, '{7, 10'b0000000010, 0}, '{9, 10'b0000000010, 1},
            '{33, 10'b0000000010, 8}, '{97, 10'b0000000110, 24}, '{122, 10'b1000000010, 27},
            '{130, 10'b0000000010, 27}, '{131, 10'b0100000010, 27}, '{142, 10'b0000001010, 27},
            '{144, 10'b0000000010, 27}, '{145, 10'b0000000001, 27}, '{146, 10'b0000000000, 27}};
    checkTab("nom");
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("nom_addr_w%0d", k), int'(adA[1 + 8 * k]), (k / 4) * 8 + k % 4);
      chk($sformatf("nom_pop_w%0d", k), int'(obsA[2 + 8 * k][9]), 1);
    end
    chk("nom_pop_count", cnt(0, 9, 0, 289), 16);
    chk("nom_getnext_count", cnt(0, 2, 0, 289), 1);
    chk("nom_done_count", cnt(0, 0, 0, 289), 1);
    for (int k = 0; k < 32; k++) chk($sformatf("rs1_addr_w%0d", k), int'(adB[1 + 8 * k]), k);
    chk("rs1_getnext_201", int'(obsB[201][2]), 1);
    chk("rs1_getnext_count", cnt(1, 2, 0, 289), 1);
    chk("rs1_busy_272", int'(obsB[272][1]), 1);
    chk("rs1_done_273", int'(obsB[273][0]), 1);
    chk("rs1_busy_273", int'(obsB[273][1]), 0);
    // stall blocking the strobes of cycles 20..24 (registered outputs: applied one cycle ahead)
    prep();
    stT[0] = 1'b1;
    for (int c = 19; c <= 23; c++) stS[c] = 1'b1;
    run(160);
    tab = '{'{19, 10'b0100000010, 2}, '{20, 10'b0000000010, 2}, '{24, 10'b0000000010, 2},
            '{25, 10'b0011000010, 2}, '{26, 10'b0000110010, 2}, '{27, 10'b0000001010, 2},
            '{29, 10'b0000000010, 2}, '{30, 10'b0000000010, 3}, '{149, 10'b0000000010, 27},
            '{150, 10'b0000000001, 27}};
    checkTab("stall");
    for (int c = 20; c <= 24; c++) chk($sformatf("stall_quiet_c%0d", c), int'(obsA[c][9:2]), 0);
    chk("stall_pop_count", cnt(0, 9, 0, 159), 16);
    chk("stall_mag_count", cnt(0, 5, 0, 159), 18);
    // stall over the getNext slot start
    prep();
    stT[0] = 1'b1;
    stS[96] = 1'b1;
    run(160);
    chk("gnstall_gn_97", int'(obsA[97][2]), 0);
    chk("gnstall_gn_98", int'(obsA[98][2]), 1);
    chk("gnstall_gn_count", cnt(0, 2, 0, 159), 1);
    chk("gnstall_addr_97", int'(adA[97]), 19);
    chk("gnstall_addr_98", int'(adA[98]), 24);
    chk("gnstall_done_146", int'(obsA[146][0]), 1);
    // startEn held high: one frame, then a new frame right after IDLE
    prep();
    for (int c = 0; c < 200; c++) stT[c] = 1'b1;
    run(160);
    chk("held_done_145", int'(obsA[145][0]), 1);
    chk("held_done_count", cnt(0, 0, 0, 159), 1);
    chk("held_busy_146", int'(obsA[146][1]), 0);
    chk("held_addr_146", int'(adA[146]), 27);
    chk("held_busy_147", int'(obsA[147][1]), 1);
    chk("held_addr_147", int'(adA[147]), 0);
    chk("held_pop_148", int'(obsA[148][9]), 1);
    // start pulses while busy and in DONE are dropped
    prep();
    stT[0] = 1'b1;
    stT[50] = 1'b1;
    stT[145] = 1'b1;
    run(160);
    chk("ign_addr_57", int'(adA[57]), 11);
    chk("ign_done_145", int'(obsA[145][0]), 1);
    chk("ign_done_count", cnt(0, 0, 0, 159), 1);
    chk("ign_busy_146", int'(obsA[146][1]), 0);
    chk("ign_busy_147", int'(obsA[147][1]), 0);
    // reset mid-RUN, then restart
    prep();
    stT[0] = 1'b1;
    stR[60] = 1'b1;
    stT[62] = 1'b1;
    run(80);
    chk("rst_pre_busy_60", int'(obsA[60][1]), 1);
    chk("rst_outs_61", int'(obsA[61]), 0);
    chk("rst_addr_61", int'(adA[61]), 0);
    chk("rst_busy_63", int'(obsA[63][1]), 1);
    chk("rst_addr_63", int'(adA[63]), 0);
    chk("rst_pop_64", int'(obsA[64][9]), 1);
    chk("rst_addr_71", int'(adA[71]), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
